// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit serializer among N_REQ byte producers. A
// round-robin arbiter picks one pending requester while idle, hands its byte
// to the serializer with a single txStart pulse, waits for the frame to
// finish (txDone), then holds off for GAP_TICKS baud ticks of idle line
// before arbitrating again.
//
// Ports
//   clk       in   system clock, rising edge
//   arst      in   synchronous active-high reset
//   brTick8x  in   1-cycle baud tick at 8x bit rate
//   req       in   [N_REQ]          per-requester byte-pending flag
//   reqData   in   [N_REQ*DATA_W]   byte of requester i at [i*DATA_W +: DATA_W]
//   grant     out  [N_REQ]          one-hot pulse: requester's byte accepted
//   txData    out  [DATA_W]         byte to serializer, held after the frame
//   txStart   out                   1-cycle pulse: serializer loads txData
//   txBusy    in                    serializer frame in progress
//   txDone    in                    1-cycle pulse: stop bit finished
//   busy      out                   arbiter not idle
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for any req; arbitration happens here only
// LAUNCH    | txStart and grant high for this one cycle
// WAIT_BUSY | waiting for serializer to report busy (or an early txDone)
// WAIT_DONE | frame in flight, waiting for txDone
// GAP       | counting brTick8x pulses of enforced idle line
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int GAP_TICKS = 8
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    brTick8x,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] reqData,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       txData,
    output logic                    txStart,
    input  logic                    txBusy,
    input  logic                    txDone,
    output logic                    busy
);

    localparam int PTR_W = $clog2(N_REQ);
    // Keep at least one bit so GAP_TICKS=0 still elaborates cleanly.
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    logic [2:0]        state_q,   state_d;
    logic [PTR_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [GAP_W-1:0]  gap_ctr_q, gap_ctr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [N_REQ-1:0]  grant_q,   grant_d;

    // Round-robin search results
    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W:0]    cand;
    logic [PTR_W:0]    win_inc;
    logic [PTR_W-1:0]  win_next;
    logic [DATA_W-1:0] win_data;
    logic [N_REQ-1:0]  win_onehot;

    // Scan rr_ptr, rr_ptr+1, ... mod N_REQ; one extra bit on cand absorbs
    // the sum before the modulo fold.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (!win_found && req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (PTR_W'(j) == win_idx) begin
                win_data      = reqData[j*DATA_W +: DATA_W];
                win_onehot[j] = 1'b1;
            end
        end
        win_inc = {1'b0, win_idx} + (PTR_W+1)'(1);
        if (win_inc >= (PTR_W+1)'(N_REQ)) begin
            win_inc = '0;
        end
        win_next = win_inc[PTR_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gap_ctr_d = gap_ctr_q;
        tx_data_d = tx_data_q;
        grant_d   = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d   = LAUNCH;
                    tx_data_d = win_data;
                    grant_d   = win_onehot;
                    rr_ptr_d  = win_next;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A short frame may finish before busy is ever seen.
                if (txDone) begin
                    state_d   = GAP;
                    gap_ctr_d = '0;
                end else if (txBusy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (txDone) begin
                    state_d   = GAP;
                    gap_ctr_d = '0;
                end
            end
            GAP: begin
                if (GAP_TICKS == 0) begin
                    state_d = IDLE;
                end else if (brTick8x) begin
                    gap_ctr_d = gap_ctr_q + 1'b1;
                    if (gap_ctr_q == GAP_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gap_ctr_q <= '0;
            tx_data_q <= '0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_ctr_q <= gap_ctr_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign txData  = tx_data_q;
    assign txStart = (state_q == LAUNCH);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int GAP_T  = 8;

    logic                    clk = 1'b0;
    logic                    arst;
    logic                    brTick8x;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] reqData;
    logic [N_REQ-1:0]        grant;
    logic [DATA_W-1:0]       txData;
    logic                    txStart;
    logic                    txBusy;
    logic                    txDone;
    logic                    busy;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .GAP_TICKS(GAP_T)) dut (
        .clk(clk), .arst(arst), .brTick8x(brTick8x), .req(req),
        .reqData(reqData), .grant(grant), .txData(txData), .txStart(txStart),
        .txBusy(txBusy), .txDone(txDone), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0]  req;
        logic [N_REQ-1:0]  grant;
        logic [DATA_W-1:0] data;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue n gap ticks, two quiet cycles between pulses; returns right after
    // the edge that samples the last pulse.
    task automatic gap_pulses(input int n, output int start_seen);
        start_seen = 0;
        for (int k = 0; k < n; k++) begin
            brTick8x = 1'b1;
            tick();
            brTick8x = 1'b0;
            if (txStart) start_seen++;
            if (k < n - 1) begin
                tick();
                if (txStart) start_seen++;
                tick();
                if (txStart) start_seen++;
            end
        end
    endtask

    // From the LAUNCH cycle: normal frame, txDone, then the full gap.
    task automatic frame_tail(input string tag);
        int s;
        tick();
        check({tag, " txStart_after_launch"}, {31'd0, txStart}, 32'd0);
        check({tag, " grant_after_launch"}, {28'd0, grant}, 32'd0);
        txBusy = 1'b1;
        tick();
        tick();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        txBusy = 1'b0;
        check({tag, " busy_in_gap"}, {31'd0, busy}, 32'd1);
        gap_pulses(GAP_T, s);
        check({tag, " txStart_in_gap"}, s, 32'd0);
        check({tag, " busy_after_gap"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        vecs[0] = '{4'b1111, 4'b0001, 8'h11};
        vecs[1] = '{4'b1111, 4'b0010, 8'h22};
        vecs[2] = '{4'b1111, 4'b0100, 8'hA5};
        vecs[3] = '{4'b1111, 4'b1000, 8'h3C};
        vecs[4] = '{4'b1111, 4'b0001, 8'h11};
        vecs[5] = '{4'b1001, 4'b1000, 8'h3C};
        vecs[6] = '{4'b0100, 4'b0100, 8'hA5};
        vecs[7] = '{4'b0011, 4'b0001, 8'h11};
        vecs[8] = '{4'b0011, 4'b0010, 8'h22};

        reqData  = {8'h3C, 8'hA5, 8'h22, 8'h11};
        arst     = 1'b1;
        req      = 4'b1111;
        brTick8x = 1'b0;
        txBusy   = 1'b0;
        txDone   = 1'b0;

        // Reset held with all requests pending
        tick();
        tick();
        check("rst grant", {28'd0, grant}, 32'd0);
        check("rst txStart", {31'd0, txStart}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst txData", {24'd0, txData}, 32'd0);
        arst = 1'b0;

        // Table: single grants and round-robin order
        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req;
            tick();
            req = '0;
            check($sformatf("v%0d grant", i), {28'd0, grant}, {28'd0, vecs[i].grant});
            check($sformatf("v%0d txStart", i), {31'd0, txStart}, 32'd1);
            check($sformatf("v%0d txData", i), {24'd0, txData}, {24'd0, vecs[i].data});
            check($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
            frame_tail($sformatf("v%0d", i));
            check($sformatf("v%0d txData_held", i), {24'd0, txData}, {24'd0, vecs[i].data});
        end

        // Gap length with a request pending throughout (rr pointer now 2)
        req = 4'b0001;
        tick();
        check("gap first grant", {28'd0, grant}, 32'b0001);
        req = 4'b0010;
        tick();
        txBusy = 1'b1;
        tick();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        txBusy = 1'b0;
        gap_pulses(GAP_T - 1, s);
        check("gap busy_after_7", {31'd0, busy}, 32'd1);
        tick();
        if (txStart) s++;
        tick();
        if (txStart) s++;
        brTick8x = 1'b1;
        tick();
        brTick8x = 1'b0;
        if (txStart) s++;
        check("gap txStart_inside", s, 32'd0);
        check("gap busy_after_8", {31'd0, busy}, 32'd0);
        tick();
        check("gap next txStart", {31'd0, txStart}, 32'd1);
        check("gap next grant", {28'd0, grant}, 32'b0010);
        check("gap next txData", {24'd0, txData}, 32'h22);
        req = '0;

        // Short frame: txDone while still waiting for busy
        tick();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        check("short busy_in_gap", {31'd0, busy}, 32'd1);
        gap_pulses(GAP_T, s);
        check("short txStart_in_gap", s, 32'd0);
        check("short back_to_idle", {31'd0, busy}, 32'd0);

        // Mid-frame reset (rr pointer 2 before the frame)
        req = 4'b0010;
        tick();
        check("mrst pre grant", {28'd0, grant}, 32'b0010);
        req = '0;
        tick();
        txBusy = 1'b1;
        tick();
        req  = 4'b0101;
        arst = 1'b1;
        tick();
        check("mrst busy", {31'd0, busy}, 32'd0);
        check("mrst grant", {28'd0, grant}, 32'd0);
        check("mrst txData", {24'd0, txData}, 32'd0);
        arst   = 1'b0;
        txBusy = 1'b0;
        tick();
        check("mrst ptr0 grant", {28'd0, grant}, 32'b0001);
        check("mrst ptr0 txData", {24'd0, txData}, 32'h11);
        req = 4'b0100;
        frame_tail("mrst f1");
        tick();
        check("mrst req2 grant", {28'd0, grant}, 32'b0100);
        check("mrst req2 txStart", {31'd0, txStart}, 32'd1);
        check("mrst req2 txData", {24'd0, txData}, 32'hA5);
        req = '0;
        frame_tail("mrst f2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
